pb_pulse_ctrl_multi: RTL and testbench

- Multi-channel successor to the single-button one-pulse controller.
- Per channel: synchronises a raw pushbutton, debounces it, and emits single-cycle enable pulses.
- Pulse generation is selected by mode: press, release, both edges, or press with auto-repeat.
- Sits between board pushbuttons and any logic needing one-cycle clock enables (manual stepping, counters, FSM advance).

---
 rtl/pb_pulse_ctrl_multi_pkg.sv | 30 +++
 rtl/pb_pulse_chan.sv | 147 ++++++++++++++
 rtl/pb_pulse_ctrl_multi.sv | 46 ++++
 tb/tb_pb_pulse_ctrl_multi.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pulse_ctrl_multi_pkg.sv
// Shared definitions for the multi-channel pushbutton pulse controller.
//   - Mode encodings driven on the 'mode' port (shared by all channels).
//   - Per-channel FSM state encoding.
//   - Helpers that decide whether a level edge produces a pulse in a mode.
package pb_pulse_ctrl_multi_pkg;

  typedef enum logic [1:0] {
    MODE_PRESS   = 2'b00,
    MODE_RELEASE = 2'b01,
    MODE_REPEAT  = 2'b10,
    MODE_BOTH    = 2'b11
  } pb_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HELD   = 2'b01,
    REPEAT = 2'b10
  } pb_chan_state_e;

  // A debounced press pulses in every mode except release-only.
  function automatic logic press_pulse_en(input logic [1:0] mode);
    return (mode != MODE_RELEASE);
  endfunction

  // A debounced release pulses only in release-only and both-edges modes.
  function automatic logic release_pulse_en(input logic [1:0] mode);
    return (mode == MODE_RELEASE) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/pb_pulse_chan.sv
// One pushbutton channel: 2-flop synchroniser, debounce counter, channel
// FSM (IDLE/HELD/REPEAT) with its repeat counter, and the registered pulse.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   i_btn    raw asynchronous button, 1 = pressed
//   i_mode   pulse mode (press / release / repeat / both)
//   o_level  debounced, registered button state
//   o_pulse  one-cycle registered enable
module pb_pulse_chan
  import pb_pulse_ctrl_multi_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int REP_DELAY  = 64,
  parameter int REP_RATE   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn,
  input  logic [1:0] i_mode,
  output logic       o_level,
  output logic       o_pulse
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [DW-1:0] r_deb_cnt;

  pb_chan_state_e r_state;
  pb_chan_state_e w_state_nxt;
  logic [RW-1:0]  r_rep_cnt;
  logic [RW-1:0]  w_rep_nxt;
  logic           r_pulse;
  logic           w_pulse_nxt;

  logic w_mismatch;
  logic w_deb_done;
  logic w_rise;
  logic w_fall;

  // The FSM looks at the level the debouncer is about to load, so state,
  // level and pulse all move on the same clock edge.
  assign w_mismatch = (r_sync2 != r_level);
  assign w_deb_done = w_mismatch && (r_deb_cnt == DEB_LAST);
  assign w_rise     = w_deb_done && r_sync2;
  assign w_fall     = w_deb_done && !r_sync2;

  // Synchroniser and debouncer: a single agreeing sample clears the count,
  // so only DEB_CYCLES consecutive disagreeing samples move the level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!w_mismatch || w_deb_done) begin
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
      if (w_deb_done) begin
        r_level <= r_sync2;
      end
    end
  end

  // FSM state, repeat counter and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rep_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  // Next-state logic. Outside repeat mode the counter is pinned at zero, so
  // switching into repeat mode while held starts the delay from that cycle,
  // and switching out of it drops straight back to HELD without a pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_rep_nxt   = r_rep_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HELD;
          w_rep_nxt   = '0;
          w_pulse_nxt = press_pulse_en(i_mode);
        end
      end
      HELD: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_rep_nxt   = '0;
          w_pulse_nxt = release_pulse_en(i_mode);
        end else if (i_mode != MODE_REPEAT) begin
          w_rep_nxt = '0;
        end else if (r_rep_cnt == DELAY_LAST) begin
          w_state_nxt = REPEAT;
          w_rep_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_rep_nxt = r_rep_cnt + RW'(1);
        end
      end
      REPEAT: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_rep_nxt   = '0;
          w_pulse_nxt = release_pulse_en(i_mode);
        end else if (i_mode != MODE_REPEAT) begin
          w_state_nxt = HELD;
          w_rep_nxt   = '0;
        end else if (r_rep_cnt == RATE_LAST) begin
          w_rep_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_rep_nxt = r_rep_cnt + RW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rep_nxt   = '0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/pb_pulse_ctrl_multi.sv
// Multi-channel pushbutton one-pulse controller. Each button gets its own
// synchroniser, debouncer and pulse FSM; mode is shared by all channels.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   btn        N raw pushbutton inputs, 1 = pressed
//   mode       00 press, 01 release, 10 press + auto-repeat, 11 both edges
//   level      N debounced button states
//   pulse      N one-cycle enables
//   any_pulse  OR of all pulse bits
module pb_pulse_ctrl_multi
  import pb_pulse_ctrl_multi_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 16,
  parameter int REP_DELAY  = 64,
  parameter int REP_RATE   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  input  logic [1:0]   mode,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse,
  output logic         any_pulse
);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    pb_pulse_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_RATE   (REP_RATE)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn[gi]),
      .i_mode  (mode),
      .o_level (level[gi]),
      .o_pulse (pulse[gi])
    );
  end

  // Pulses are already registered, so this adds no latency.
  assign any_pulse = |pulse;

endmodule

// File: tb/tb_pb_pulse_ctrl_multi.sv
// Self-checking bench for pb_pulse_ctrl_multi: directed scenarios with
// literal expectations followed by randomized button/mode/reset activity,
// all checked every cycle against a behavioural model.
module tb_pb_pulse_ctrl_multi;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RR  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [1:0]   mode;
  logic [N-1:0] level;
  logic [N-1:0] pulse;
  logic         any_pulse;

  int assertCount = 0;
  int failCount   = 0;
  int dutPulses[N];

  // Behavioural model: button history, mismatch run length, accepted level,
  // and for held buttons the cycles elapsed toward the next repeat.
  bit mH1[N];
  bit mH2[N];
  bit mLvl[N];
  bit mPul[N];
  bit mInRep[N];
  int mRun[N];
  int mSince[N];

  always #5 clk = ~clk;

  pb_pulse_ctrl_multi #(
    .N          (N),
    .DEB_CYCLES (DEB),
    .REP_DELAY  (RD),
    .REP_RATE   (RR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .mode      (mode),
    .level     (level),
    .pulse     (pulse),
    .any_pulse (any_pulse)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] b, input logic [1:0] m);
    @(negedge clk);
    btn  = b;
    mode = m;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model, advanced on every clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          mH1[i] = 0; mH2[i] = 0; mLvl[i] = 0; mPul[i] = 0;
          mInRep[i] = 0; mRun[i] = 0; mSince[i] = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          bit s;
          bit newLvl;
          s      = mH2[i];
          mH2[i] = mH1[i];
          mH1[i] = btn[i];
          newLvl = mLvl[i];
          if (s != mLvl[i]) mRun[i]++;
          else mRun[i] = 0;
          if (mRun[i] == DEB) begin
            newLvl  = s;
            mRun[i] = 0;
          end
          mPul[i] = 0;
          if (newLvl && !mLvl[i]) begin
            mPul[i]   = (mode != 2'b01);
            mSince[i] = 0;
            mInRep[i] = 0;
          end else if (!newLvl && mLvl[i]) begin
            mPul[i]   = (mode == 2'b01) || (mode == 2'b11);
            mSince[i] = 0;
            mInRep[i] = 0;
          end else if (newLvl) begin
            if (mode != 2'b10) begin
              mSince[i] = 0;
              mInRep[i] = 0;
            end else begin
              mSince[i]++;
              if (mSince[i] == (mInRep[i] ? RR : RD)) begin
                mPul[i]   = 1;
                mSince[i] = 0;
                mInRep[i] = 1;
              end
            end
          end
          mLvl[i] = newLvl;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      logic [N-1:0] expLevel;
      logic [N-1:0] expPulse;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        expLevel[i] = mLvl[i];
        expPulse[i] = mPul[i];
        if (pulse[i] === 1'b1) dutPulses[i]++;
      end
      checkOutput("model_level", 32'(level), 32'(expLevel));
      checkOutput("model_pulse", 32'(pulse), 32'(expPulse));
      checkOutput("model_any", 32'(any_pulse), 32'(|expPulse));
    end
  end

  initial begin
    int p;
    int holdLeft[N];
    int rstLeft;

    for (int i = 0; i < N; i++) dutPulses[i] = 0;
    rst  = 1'b0;
    btn  = 4'hF;
    mode = 2'b00;

    // Reset held with buttons pressed, then release.
    waitEdges(3);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_pulse", 32'(pulse), 32'h0);
    checkOutput("rst_any", 32'(any_pulse), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    waitEdges(5);
    checkOutput("boot_level_e5", 32'(level), 32'h0);
    waitEdges(1);
    checkOutput("boot_level_e6", 32'(level), 32'hF);
    checkOutput("boot_pulse_e6", 32'(pulse), 32'hF);
    checkOutput("boot_any_e6", 32'(any_pulse), 32'h1);
    waitEdges(1);
    checkOutput("boot_pulse_e7", 32'(pulse), 32'h0);
    applyStimulus(4'h0, 2'b00);
    waitEdges(15);

    // Short glitch is rejected.
    p = dutPulses[0];
    applyStimulus(4'b0001, 2'b00);
    repeat (2) @(negedge clk);
    applyStimulus(4'b0000, 2'b00);
    waitEdges(15);
    checkOutput("glitch_level", 32'(level), 32'h0);
    checkOutput("glitch_pulses", 32'(dutPulses[0] - p), 32'h0);

    // Clean press in mode 00.
    applyStimulus(4'b0001, 2'b00);
    waitEdges(5);
    checkOutput("press_level_e5", 32'(level), 32'h0);
    waitEdges(1);
    checkOutput("press_level_e6", 32'(level), 32'h1);
    checkOutput("press_pulse_e6", 32'(pulse), 32'h1);
    waitEdges(1);
    checkOutput("press_pulse_e7", 32'(pulse), 32'h0);
    applyStimulus(4'b0000, 2'b00);
    waitEdges(15);

    // Release-only mode.
    p = dutPulses[1];
    applyStimulus(4'b0010, 2'b01);
    repeat (19) @(negedge clk);
    checkOutput("rel_no_press_pulse", 32'(dutPulses[1] - p), 32'h0);
    applyStimulus(4'b0000, 2'b01);
    waitEdges(5);
    checkOutput("rel_pulse_e5", 32'(pulse), 32'h0);
    waitEdges(1);
    checkOutput("rel_pulse_e6", 32'(pulse), 32'h2);
    waitEdges(1);
    checkOutput("rel_pulse_e7", 32'(pulse), 32'h0);
    waitEdges(10);

    // Both-edges mode: exactly two pulses.
    p = dutPulses[1];
    applyStimulus(4'b0010, 2'b11);
    repeat (19) @(negedge clk);
    applyStimulus(4'b0000, 2'b11);
    waitEdges(15);
    checkOutput("both_pulses", 32'(dutPulses[1] - p), 32'h2);

    // Auto-repeat: P at edge 6, repeats at 14, 17, 20, 23.
    applyStimulus(4'b0100, 2'b10);
    waitEdges(6);
    checkOutput("rep_P", 32'(pulse), 32'h4);
    waitEdges(7);
    checkOutput("rep_e13", 32'(pulse), 32'h0);
    waitEdges(1);
    checkOutput("rep_e14", 32'(pulse), 32'h4);
    waitEdges(3);
    checkOutput("rep_e17", 32'(pulse), 32'h4);
    waitEdges(2);
    checkOutput("rep_e19", 32'(pulse), 32'h0);
    waitEdges(1);
    checkOutput("rep_e20", 32'(pulse), 32'h4);
    applyStimulus(4'b0000, 2'b10);
    p = dutPulses[2];
    waitEdges(20);
    checkOutput("rep_after_release", 32'(dutPulses[2] - p), 32'h1);
    checkOutput("rep_release_level", 32'(level), 32'h0);

    // Leave and re-enter repeat mode while held.
    applyStimulus(4'b1000, 2'b10);
    waitEdges(14);
    checkOutput("sw_first_repeat", 32'(pulse), 32'h8);
    waitEdges(1);
    applyStimulus(4'b1000, 2'b00);
    p = dutPulses[3];
    waitEdges(20);
    checkOutput("sw_repeats_stopped", 32'(dutPulses[3] - p), 32'h0);
    applyStimulus(4'b1000, 2'b10);
    waitEdges(7);
    checkOutput("sw_reenter_e7", 32'(pulse), 32'h0);
    waitEdges(1);
    checkOutput("sw_reenter_e8", 32'(pulse), 32'h8);
    applyStimulus(4'b0000, 2'b00);
    waitEdges(15);

    // Reset mid-hold (ch1) and mid-debounce (ch0).
    applyStimulus(4'b0010, 2'b00);
    waitEdges(15);
    applyStimulus(4'b0011, 2'b00);
    waitEdges(2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_level", 32'(level), 32'h0);
    checkOutput("midrst_pulse", 32'(pulse), 32'h0);
    checkOutput("midrst_any", 32'(any_pulse), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    waitEdges(5);
    checkOutput("midrst_pulse_e5", 32'(pulse), 32'h0);
    waitEdges(1);
    checkOutput("midrst_pulse_e6", 32'(pulse), 32'h3);
    checkOutput("midrst_level_e6", 32'(level), 32'h3);
    waitEdges(1);
    checkOutput("midrst_pulse_e7", 32'(pulse), 32'h0);

    // Concurrent presses.
    applyStimulus(4'b0000, 2'b00);
    waitEdges(15);
    applyStimulus(4'b1011, 2'b00);
    waitEdges(5);
    checkOutput("conc_any_e5", 32'(any_pulse), 32'h0);
    waitEdges(1);
    checkOutput("conc_pulse_e6", 32'(pulse), 32'hB);
    checkOutput("conc_any_e6", 32'(any_pulse), 32'h1);
    waitEdges(1);
    checkOutput("conc_any_e7", 32'(any_pulse), 32'h0);

    // Randomized activity, checked by the model every cycle.
    for (int i = 0; i < N; i++) holdLeft[i] = $urandom_range(1, 30);
    rstLeft = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (holdLeft[i] == 0) begin
          btn[i]      = ~btn[i];
          holdLeft[i] = $urandom_range(1, 30);
        end else begin
          holdLeft[i]--;
        end
      end
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if (rstLeft > 0) begin
        rstLeft--;
        if (rstLeft == 0) rst = 1'b1;
      end else if ($urandom_range(0, 999) == 0) begin
        rst     = 1'b0;
        rstLeft = 2;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    waitEdges(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
